// File: rtl/sbqm_wait_est.sv
// Queue wait-time estimator: resynchronises the people count, divides T_SERVE*(p+t-1) by the teller count.
// Optional build macro WTIME_BCD_EN adds a 3-digit BCD copy of wtime (double-dabble after the divide).
module sbqm_wait_est #(
    parameter int N       = 3,
    parameter int TW      = 2,
    parameter int T_SERVE = 3,
    parameter int WW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  pcount,
    input  logic [TW-1:0] tcount,
    output logic [WW-1:0] wtime,
    output logic          valid,
    output logic          busy,
    output logic          full,
    output logic          empty,
`ifdef WTIME_BCD_EN
    output logic [11:0]   wtime_bcd,
`endif
    output logic          no_teller
);

    localparam int NW = WW + 2;
    localparam int CW = $clog2(WW + 1);
`ifdef WTIME_BCD_EN
    localparam int SATV = 2**WW - 1;
    localparam logic [11:0] SAT_BCD = {4'(SATV / 100), 4'((SATV / 10) % 10), 4'(SATV % 10)};
    typedef enum logic [2:0] {IDLE, LOAD, DIV, BCD, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, DIV, DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [N-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N-1:0]  last_p_q, last_p_d;
    logic [TW-1:0] last_t_q, last_t_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] rem_q, rem_d, div_q, div_d;
    logic [WW-1:0] quo_q, quo_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wtime_q, wtime_d;
    logic          valid_q, valid_d, busy_q, busy_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          no_teller_q, no_teller_d;
`ifdef WTIME_BCD_EN
    logic [11:0]   bcd_q, bcd_d, wtime_bcd_q, wtime_bcd_d;
    logic [WW-1:0] bin_q, bin_d;
    logic [11:0]   adj;
    logic [WW+11:0] shifted;
`endif

    logic          stable, changed, ge;
    logic [NW-1:0] num;
    logic [TW:0]   trial;
    logic [WW-1:0] qbits, res;

    always_comb begin
        state_d     = state_q;
        s1_d        = pcount;
        s2_d        = s1_q;
        s3_d        = s2_q;
        last_p_d    = last_p_q;
        last_t_d    = last_t_q;
        pend_d      = pend_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        wtime_d     = wtime_q;
        valid_d     = 1'b0;
        no_teller_d = no_teller_q;
        full_d      = (s2_q == '1);
        empty_d     = (s2_q == '0);
`ifdef WTIME_BCD_EN
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        wtime_bcd_d = wtime_bcd_q;
        adj         = '0;
        shifted     = '0;
`endif
        // s2==s3 means the synchronised count has settled across all bits.
        stable  = (s2_q == s3_q);
        changed = stable && ((s3_q != last_p_q) || (tcount != last_t_q));
        num     = NW'(T_SERVE) * (NW'(s3_q) + NW'(tcount) - NW'(1));
        trial   = {rem_q, quo_q[WW-1]};
        ge      = (trial >= {1'b0, div_q});
        qbits   = {quo_q[WW-2:0], ge};
        res     = ovf_q ? '1 : qbits;

        // LOAD latches the current operands, so a change seen there is already covered.
        if (changed && state_q != LOAD) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                last_p_d    = s3_q;
                last_t_d    = tcount;
                no_teller_d = (tcount == '0);
                if (s3_q == '0) begin
                    wtime_d = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef WTIME_BCD_EN
                    wtime_bcd_d = '0;
`endif
                end else if (tcount == '0) begin
                    wtime_d = '1;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef WTIME_BCD_EN
                    wtime_bcd_d = SAT_BCD;
`endif
                end else begin
                    // The top two numerator bits alone reaching the divisor means the quotient overflows WW bits.
                    ovf_d   = ((num >> WW) >= NW'(tcount));
                    rem_d   = TW'(num >> WW);
                    quo_d   = num[WW-1:0];
                    div_d   = tcount;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = ge ? TW'(trial - {1'b0, div_q}) : trial[TW-1:0];
                quo_d = qbits;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WW - 1)) begin
                    quo_d = res;
`ifdef WTIME_BCD_EN
                    bin_d   = res;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = BCD;
`else
                    wtime_d = res;
                    valid_d = 1'b1;
                    state_d = DONE;
`endif
                end
            end
`ifdef WTIME_BCD_EN
            BCD: begin
                for (int i = 0; i < 3; i++) begin
                    adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
                end
                shifted = {adj, bin_q} << 1;
                bcd_d   = shifted[WW+11:WW];
                bin_d   = shifted[WW-1:0];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WW - 1)) begin
                    wtime_d     = quo_q;
                    wtime_bcd_d = shifted[WW+11:WW];
                    valid_d     = 1'b1;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                if (pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = pend_d | (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            last_p_q    <= '0;
            last_t_q    <= '0;
            pend_q      <= 1'b0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            wtime_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            no_teller_q <= 1'b0;
`ifdef WTIME_BCD_EN
            bcd_q       <= '0;
            bin_q       <= '0;
            wtime_bcd_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            last_p_q    <= last_p_d;
            last_t_q    <= last_t_d;
            pend_q      <= pend_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            wtime_q     <= wtime_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            no_teller_q <= no_teller_d;
`ifdef WTIME_BCD_EN
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            wtime_bcd_q <= wtime_bcd_d;
`endif
        end
    end

    assign wtime     = wtime_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign no_teller = no_teller_q;
`ifdef WTIME_BCD_EN
    assign wtime_bcd = wtime_bcd_q;
`endif

endmodule

// File: tb/tb_sbqm_wait_est.sv
// Scoreboard bench for sbqm_wait_est: a stimulus process pushes expected results, a monitor pops them on valid.
module tb_sbqm_wait_est;
    localparam int N       = 3;
    localparam int TW      = 2;
    localparam int T_SERVE = 3;
    localparam int WW      = 8;
    localparam int EW      = WW + 13;
`ifdef WTIME_BCD_EN
    localparam int LAT_DIV = 2 * WW + 5;
`else
    localparam int LAT_DIV = WW + 5;
`endif
    localparam int LAT_NODIV = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  pcount;
    logic [TW-1:0] tcount;
    logic [WW-1:0] wtime;
    logic          valid, busy, full, empty, no_teller;
`ifdef WTIME_BCD_EN
    logic [11:0]   wtime_bcd;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_p  = 0;
    int cur_t  = 0;
    logic [EW-1:0] exp_q[$];

    sbqm_wait_est #(.N(N), .TW(TW), .T_SERVE(T_SERVE), .WW(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pcount    (pcount),
        .tcount    (tcount),
        .wtime     (wtime),
        .valid     (valid),
        .busy      (busy),
        .full      (full),
        .empty     (empty),
`ifdef WTIME_BCD_EN
        .wtime_bcd (wtime_bcd),
`endif
        .no_teller (no_teller)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: wait = T_SERVE*(p+t-1)/t minutes, saturated; 0 with an empty queue, max without tellers.
    function automatic int model_wait(input int p, input int t);
        int q;
        if (p == 0) return 0;
        if (t == 0) return 2**WW - 1;
        q = (T_SERVE * (p + t - 1)) / t;
        return (q > 2**WW - 1) ? 2**WW - 1 : q;
    endfunction

    function automatic logic [EW-1:0] pack_exp(input int p, input int t);
        int w;
        logic [11:0] bcd;
        w   = model_wait(p, t);
        bcd = {4'(w / 100), 4'((w / 10) % 10), 4'(w % 10)};
        return {(t == 0), bcd, WW'(w)};
    endfunction

    task automatic set_p(input int v);
        @(negedge clk);
        pcount = N'(v);
        cur_p  = v;
        exp_q.push_back(pack_exp(cur_p, cur_t));
    endtask

    task automatic set_t(input int v);
        @(negedge clk);
        tcount = TW'(v);
        cur_t  = v;
        exp_q.push_back(pack_exp(cur_p, cur_t));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    // Change pcount and count edges from the one where s1 samples it until valid.
    task automatic measure_p(input int v, input int exp_lat, input string name);
        int  n;
        bit  hit, saw_busy;
        set_p(v);
        n = 0; hit = 0; saw_busy = 0;
        while (!hit && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (busy) saw_busy = 1;
            if (valid) hit = 1;
        end
        check({name, "_latency"}, n - 1, exp_lat);
        check({name, "_busy_seen"}, int'(saw_busy), 1);
        drain(name);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wtime", wtime, e[WW-1:0]);
                    check("no_teller", no_teller, e[EW-1]);
`ifdef WTIME_BCD_EN
                    check("wtime_bcd", wtime_bcd, e[WW+11:WW]);
`endif
                end
            end
        end
    end

    initial begin
        int v, tn;
        rst = 1'b1; pcount = '0; tcount = '0;
        repeat (3) @(negedge clk);
        check("rst_wtime", wtime, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_no_teller", no_teller, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_rst_busy", busy, 0);

        set_t(2);                                   drain("t2_p0");
        measure_p(5, LAT_DIV, "p5_t2");
        check("p5_full", full, 0);
        check("p5_empty", empty, 0);
        set_t(1);                                   drain("p5_t1");
        measure_p(7, LAT_DIV, "p7_t1");
        check("p7_full", full, 1);
        set_t(3);                                   drain("p7_t3");
        set_t(0);                                   drain("p7_t0");
        measure_p(4, LAT_NODIV, "p4_t0");
        check("p4_t0_no_teller", no_teller, 1);
        measure_p(0, LAT_NODIV, "p0_t0");
        check("p0_empty", empty, 1);

        // Operand change while the divider is busy: both results, in order, nothing else.
        set_t(2);                                   drain("pre_mid");
        set_p(5);
        repeat (8) @(negedge clk);
        set_p(6);
        drain("mid_div");
        repeat (30) @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (j == 1) begin
                    if ($urandom_range(0, 3) != 0) break;
                    repeat ($urandom_range(6, 14)) @(negedge clk);
                end
                if ($urandom_range(0, 1) == 1) begin
                    do v = $urandom_range(0, 2**N - 1); while (v == cur_p);
                    set_p(v);
                end else begin
                    do v = $urandom_range(0, 2**TW - 1); while (v == cur_t);
                    set_t(v);
                end
            end
            drain("rand");
            check("rand_full", full, int'(cur_p == 2**N - 1));
            check("rand_empty", empty, int'(cur_p == 0));
        end

        // Asynchronous reset in the middle of a divide.
        if (cur_t == 0) begin set_t(1); drain("pre_rst_t"); end
        if (cur_p != 7) begin set_p(7); drain("pre_rst_p"); end
        tn = (cur_t == 1) ? 3 : 1;
        set_t(tn);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_wtime", wtime, 0);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        exp_q.delete();
        pcount = '0; tcount = '0; cur_p = 0; cur_t = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_wtime", wtime, 0);
        check("post_rst_empty", empty, 1);
        check("leftover_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sbqm_wait_est.md
Name: sbqm_wait_est

Overview:
- Downstream consumer of the queue people counter (pcount, 0..2^N-1).
- Computes estimated customer wait time from the people count and the number of active tellers, plus queue full/empty flags.
- Drives the display/alert stage.
- Synchronous to clk; pcount arrives from the sensor-edge-clocked counter domain and is resynchronised here.

Parameters:
- N, 3, pcount width.
- TW, 2, tcount width (0..3 tellers).
- T_SERVE, 3, service time per customer (minutes).
- WW, 8, wtime width; also the number of divider iterations.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state and outputs.
- pcount  in  N  people in queue (asynchronous domain).
- tcount  in  TW  active tellers (quasi-static, synchronous).
- wtime  out  WW  estimated wait, minutes, registered.
- valid  out  1  one-cycle pulse when wtime updates.
- busy  out  1  high while a computation is pending or running.
- full  out  1  synced pcount == 2^N-1.
- empty  out  1  synced pcount == 0.
- no_teller  out  1  tcount == 0 at last load.

Behaviour:
- Reset values: wtime=0, valid=0, busy=0, full=0, empty=1, no_teller=0, FSM=IDLE, sync regs=0.
- Input capture:
  - pcount passes through 2 flops (s1, s2).
  - s2 is compared with a third flop s3.
  - The operand is "stable" when s2==s3. This rejects multi-bit skew.
  - full/empty are derived from s3.
- Change detect:
  - Stable and (s3 != last_p or tcount != last_t) sets pending=1.
  - last_p and last_t are the operands of the last LOAD.
- FSM IDLE -> LOAD:
  - Transition when pending=1; pending clears on entry to LOAD.
- LOAD (1 cycle): latch last_p=s3, last_t=tcount.
  - If s3==0: result=0; go to DONE.
  - Else if tcount==0: result=all-ones, no_teller=1; go to DONE.
  - Else: numerator = T_SERVE*(s3+tcount-1) in WW+2 bits, divisor = tcount, no_teller=0; go to DIV.
- DIV (exactly WW cycles):
  - Restoring divide, one quotient bit per cycle, MSB first.
  - Quotient is floor(numerator/tcount).
  - If the quotient does not fit in WW bits, result = all-ones (saturate).
- DONE (1 cycle): wtime<=result, valid=1; go to IDLE.
  - Pending may already be set again, in which case the next LOAD follows directly.
- busy = pending | (FSM != IDLE).
- Latency: valid is high exactly WW+5 clocks after the clk edge at which s1 first samples a new pcount (2 sync + 1 compare + LOAD + WW DIV + DONE).
  - With tcount==0 or pcount==0 (no DIV), latency is 5.
- Operand change during LOAD/DIV/DONE:
  - The current computation completes with its latched operands.
  - pending is set, and exactly one recompute follows with the newest operands. Intermediate values are never reported.
- wtime holds its value between valid pulses.
- rst asserted mid-DIV: immediate clear to reset values; no valid pulse.

Optional Feature:
- Macro: WTIME_BCD_EN.
- Defined:
  - Adds output wtime_bcd [11:0], 3 BCD digits of wtime.
  - After DIV, a BCD state runs sequential double-dabble for exactly WW cycles before DONE.
  - Latency becomes 2*WW+5.
  - wtime and wtime_bcd update together at valid.
  - Saturated value 255 is shown as 0x255.
- Undefined: no wtime_bcd port, no BCD state; latency as above.

Test Plan:
- Reset: assert rst mid-run -> wtime=0, valid=0, busy=0, empty=1, full=0 within the same cycle (asynchronous).
- pcount 0->5, tcount=2 -> busy rises, single valid pulse 13 clocks later, wtime=9 (3*6/2).
- pcount=7, tcount=1 -> full=1, wtime=21; then tcount=3 -> wtime=9 (27/3).
- tcount=0, pcount=4 -> no_teller=1, wtime=255 after 5 clocks; pcount=0 -> wtime=0, empty=1.
- pcount 5->6 mid-DIV (tcount=2) -> valid with wtime=9, then a second valid with wtime=10 (21/2 floor); no third pulse.
- WTIME_BCD_EN defined, pcount=7, tcount=1 -> wtime_bcd=0x021 together with wtime=21 at valid, 21 clocks after change.
